bcd_convert_arbiter: RTL and testbench

Shared, iterative binary-to-BCD conversion engine with a round-robin front end. Several display sources, such as the score and the current card value, each request an 8-bit value be converted to three BCD digits. The block grants one requester at a time and runs an 8-step shift-and-add-3 sequence on a single shared datapath. It returns the 12-bit BCD result with a per-requester completion pulse, and feeds the digit-to-segment/VGA text logic.

---
 rtl/bcd_convert_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bcd_convert_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter
//
// Shared iterative binary-to-BCD converter with a round-robin front end.
// Each requester presents an 8-bit operand; one requester is granted at a
// time, its operand is converted with eight shift-and-add-3 iterations on a
// single datapath, and the three-digit BCD result is returned together with
// a completion pulse addressed to that requester.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst_n    in   synchronous active-low reset
//   req      in   per-requester request level, held until the matching ack
//   num_in   in   packed operands, requester k on bits [8k+7:8k]
//   ack      out  one-cycle pulse, request k accepted and operand captured
//   done     out  one-cycle pulse, bcd_out holds requester k's result
//   bcd_out  out  {hundreds, tens, ones}, held until the next done
//   busy     out  high from the ack cycle through the done cycle
//   owner    out  requester currently or most recently served
//
// Schedule: grant edge E0 raises ack, edges E1..E8 run the iterations,
// edge E9 loads bcd_out and raises done, and edge E10 may grant again.

module bcd_convert_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] num_in,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic [11:0]          bcd_out,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     last_q;
    logic [IDX_W-1:0]     owner_q;
    // Working BCD digits in [19:8], remaining operand bits in [7:0]; one
    // register so the left shift moves the operand MSB straight into bcd[0].
    logic [19:0]          sr_q;
    logic [2:0]           count_q;
    logic [11:0]          bcd_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 busy_q;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic [7:0]           win_opnd;
    logic [11:0]          corr;
    logic [19:0]          sr_d;
    logic [NUM_REQ-1:0]   owner_oh;

    // Round-robin winner: scan from last+1 upward, wrapping modulo NUM_REQ.
    // The first requesting index met along that rotation wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise the tool infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_opnd  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && req[j] && ((int'(last_q) + i) % NUM_REQ) == j) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(j);
                    win_oh[j] = 1'b1;
                    win_opnd  = num_in[8*j +: 8];
                end
            end
        end
    end

    // One conversion step: correct every digit above 4 by +3, then shift
    // the whole {bcd, operand} pair left by one.
    always_comb begin
        corr = sr_q[19:8];
        for (int d = 0; d < 3; d++) begin
            if (sr_q[8+4*d +: 4] > 4'd4) begin
                corr[4*d +: 4] = sr_q[8+4*d +: 4] + 4'd3;
            end
        end
        sr_d = {corr, sr_q[7:0]} << 1;

        owner_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (owner_q == IDX_W'(j)) begin
                owner_oh[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            sr_q    <= '0;
            count_q <= '0;
            bcd_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        sr_q    <= {12'h000, win_opnd};
                        count_q <= '0;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        ack_q   <= win_oh;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr_q    <= sr_d;
                    count_q <= count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through the done cycle; IDLE decides
                    // on the next edge whether it drops or a new grant starts.
                    bcd_q   <= sr_q[19:8];
                    done_q  <= owner_oh;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign busy    = busy_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter
//
// Bench for bcd_convert_arbiter. A cycle-level reference model computes the
// expected ack/done/busy/owner/bcd_out from the sampled inputs using plain
// decimal arithmetic and a phase counter, and is compared every cycle.
// Directed sequences exercise reset, single conversions, a full 0..255
// sweep, round-robin rotation, operand stability and reset mid-conversion;
// a randomized phase follows.

module tb_bcd_convert_arbiter;

    localparam int NUM_REQ = 2;
    localparam int IDX_W   = 2;
    localparam int NW      = 8 * NUM_REQ;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NW-1:0]        num_in;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic [11:0]          bcd_out;
    logic                 busy;
    logic [IDX_W-1:0]     owner;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_convert_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .num_in  (num_in),
        .ack     (ack),
        .done    (done),
        .bcd_out (bcd_out),
        .busy    (busy),
        .owner   (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    // ---------------- reference model ----------------
    int m_phase = 0;
    int m_last  = NUM_REQ - 1;
    int m_res   = 0;
    int e_ack   = 0;
    int e_done  = 0;
    int e_busy  = 0;
    int e_owner = 0;
    int e_bcd   = 0;
    int s_rst, s_req, s_num;

    // Phase 0 means the next edge may grant; a grant starts phase 1 and the
    // result appears when the phase reaches 10 (nine edges after the grant).
    function automatic void model_step();
        if (s_rst == 0) begin
            m_phase = 0;
            m_last  = NUM_REQ - 1;
            e_ack   = 0;
            e_done  = 0;
            e_busy  = 0;
            e_owner = 0;
            e_bcd   = 0;
        end else begin
            e_ack  = 0;
            e_done = 0;
            if (m_phase == 0) begin
                e_busy = 0;
                for (int i = 1; i <= NUM_REQ; i++) begin
                    int k;
                    k = (m_last + i) % NUM_REQ;
                    if (e_busy == 0 && ((s_req >> k) & 1) == 1) begin
                        e_ack   = 1 << k;
                        e_owner = k;
                        m_last  = k;
                        m_res   = to_bcd((s_num >> (8 * k)) & 255);
                        e_busy  = 1;
                        m_phase = 1;
                    end
                end
            end else begin
                m_phase++;
                if (m_phase == 10) begin
                    e_done  = 1 << e_owner;
                    e_bcd   = m_res;
                    m_phase = 0;
                end
            end
        end
    endfunction

    // Inputs are captured on the falling edge (stable around the rising
    // edge), outputs compared 2 time units after the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            s_rst = int'(rst_n);
            s_req = int'(req);
            s_num = int'(num_in);
            @(posedge clk);
            #2;
            model_step();
            check("ack",     int'(ack),     e_ack);
            check("done",    int'(done),    e_done);
            check("busy",    int'(busy),    e_busy);
            check("owner",   int'(owner),   e_owner);
            check("bcd_out", int'(bcd_out), e_bcd);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_num(input int k, input int v);
        num_in = (num_in & ~(NW'(255) << (8 * k))) | (NW'(v) << (8 * k));
    endtask

    task automatic wait_ack(input int k, output int seen, output int cyc);
        seen = 0;
        cyc  = 0;
        while (seen == 0 && cyc < 40) begin
            tick();
            cyc++;
            if (((int'(ack) >> k) & 1) == 1) seen = 1;
        end
    endtask

    task automatic wait_done(input int k, output int seen, output int cyc);
        seen = 0;
        cyc  = 0;
        while (seen == 0 && cyc < 40) begin
            tick();
            cyc++;
            if (((int'(done) >> k) & 1) == 1) seen = 1;
        end
    endtask

    task automatic do_conv(input int k, input int val);
        int seen, cyc;
        set_num(k, val);
        req = req | NUM_REQ'(1 << k);
        wait_ack(k, seen, cyc);
        check($sformatf("conv_ack_r%0d_v%0d", k, val), seen, 1);
        req = req & ~NUM_REQ'(1 << k);
        wait_done(k, seen, cyc);
        check($sformatf("conv_done_r%0d_v%0d", k, val), seen, 1);
        check($sformatf("conv_latency_r%0d_v%0d", k, val), cyc, 9);
        check($sformatf("conv_result_r%0d_v%0d", k, val), int'(bcd_out), to_bcd(val));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen, cyc;
        int acks[$];
        int ack_cyc[$];
        int res[$];

        rst_n  = 1'b0;
        req    = '0;
        num_in = '0;

        // Reset held for three cycles with random requests.
        for (int i = 0; i < 3; i++) begin
            req    = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            num_in = NW'($urandom);
            tick();
        end
        check("rst_ack",   int'(ack),     0);
        check("rst_done",  int'(done),    0);
        check("rst_busy",  int'(busy),    0);
        check("rst_owner", int'(owner),   0);
        check("rst_bcd",   int'(bcd_out), 0);
        rst_n = 1'b1;
        req   = '0;
        tick();

        // Single requests at the operand extremes.
        do_conv(0, 0);
        do_conv(0, 255);

        // Exhaustive sweep on requester 1.
        for (int v = 0; v < 256; v++) begin
            do_conv(1, v);
        end

        // Round-robin with both requesters held high.
        set_num(0, 7);
        set_num(1, 42);
        req = '1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            for (int j = 0; j < NUM_REQ; j++) begin
                if (((int'(ack) >> j) & 1) == 1) begin
                    acks.push_back(j);
                    ack_cyc.push_back(c);
                end
            end
            if (done != '0) res.push_back(int'(bcd_out));
        end
        req = '0;
        check("rr_ack_count", acks.size(), 4);
        for (int i = 0; i < acks.size() && i < 4; i++) begin
            check($sformatf("rr_order_%0d", i), acks[i], i % 2);
            if (i > 0) check($sformatf("rr_gap_%0d", i), ack_cyc[i] - ack_cyc[i-1], 10);
        end
        check("rr_res_count", res.size(), 4);
        for (int i = 0; i < res.size() && i < 4; i++) begin
            check($sformatf("rr_res_%0d", i), res[i], (i % 2 == 0) ? 'h007 : 'h042);
        end
        tick();

        // Operand changed right after ack must not disturb the result.
        set_num(0, 12);
        req = NUM_REQ'(1);
        wait_ack(0, seen, cyc);
        check("stab_ack", seen, 1);
        set_num(0, 200);
        req = '0;
        wait_done(0, seen, cyc);
        check("stab_done", seen, 1);
        check("stab_result", int'(bcd_out), 'h012);

        // Reset in the middle of a conversion for requester 1.
        set_num(1, 123);
        req = NUM_REQ'(2);
        wait_ack(1, seen, cyc);
        check("mid_ack", seen, 1);
        repeat (4) tick();
        rst_n = 1'b0;
        set_num(1, 77);
        tick();
        check("mid_rst_done", int'(done),    0);
        check("mid_rst_bcd",  int'(bcd_out), 0);
        check("mid_rst_busy", int'(busy),    0);
        rst_n = 1'b1;
        wait_ack(1, seen, cyc);
        check("mid_reack", seen, 1);
        req = '0;
        wait_done(1, seen, cyc);
        check("mid_redone", seen, 1);
        check("mid_latency", cyc, 9);
        check("mid_result", int'(bcd_out), 'h077);

        // Randomized traffic with occasional resets; the model checks it all.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                int bitk, ak;
                bitk = (int'(req) >> k) & 1;
                ak   = (int'(ack) >> k) & 1;
                if (bitk == 1 && ak == 1 && $urandom_range(0, 3) != 0) begin
                    req = req & ~NUM_REQ'(1 << k);
                end else if (bitk == 0) begin
                    set_num(k, int'($urandom_range(0, 255)));
                    if ($urandom_range(0, 2) == 0) req = req | NUM_REQ'(1 << k);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        req   = '0;
        repeat (15) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
